// File: rtl/viterbi_ber_checker.sv
// BER checker: learns the tx->rx latency of the encoder/channel/decoder chain,
// locks onto it, then counts compared bits and bit errors.
module viterbi_ber_checker #(
  parameter int MAX_LAT  = 64,
  parameter int LOCK_WIN = 32,
  parameter int LOSS_THR = 8,
  parameter int CNT_W    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tx_bit_i,
  input  logic                       tx_valid_i,
  input  logic                       rx_bit_i,
  input  logic                       rx_valid_i,
  input  logic                       clear_i,
  output logic                       locked_o,
  output logic [$clog2(MAX_LAT)-1:0] latency_o,
  output logic [CNT_W-1:0]           bit_ct_o,
  output logic [CNT_W-1:0]           err_ct_o,
  output logic                       err_flag_o
);

  localparam int LW  = $clog2(MAX_LAT);
  localparam int FW  = LW + 1;
  localparam int RW  = $clog2(LOCK_WIN + 1);
  localparam int EW  = $clog2(LOSS_THR + 1);

  typedef enum logic {ST_SEARCH, ST_LOCKED} state_t;

  state_t             state, state_d;
  logic [MAX_LAT-1:0] hist, hist_d;
  logic [FW-1:0]      fill, fill_d;
  logic [LW-1:0]      cand, cand_d;
  logic [RW-1:0]      run, run_d;
  logic [RW-1:0]      win_ct, win_ct_d;
  logic [EW-1:0]      win_err, win_err_d;
  logic               locked_d;
  logic [LW-1:0]      latency_d;
  logic [CNT_W-1:0]   bit_ct_d, err_ct_d;
  logic               err_flag_d;
  logic               compare, hit;

  // A sample is only judged once the candidate tap holds real tx history.
  assign compare = rx_valid_i && (FW'(cand) < fill);
  assign hit     = (rx_bit_i == hist[cand]);

  always_comb begin
    state_d    = state;
    hist_d     = hist;
    fill_d     = fill;
    cand_d     = cand;
    run_d      = run;
    win_ct_d   = win_ct;
    win_err_d  = win_err;
    locked_d   = locked_o;
    latency_d  = latency_o;
    bit_ct_d   = bit_ct_o;
    err_ct_d   = err_ct_o;
    err_flag_d = 1'b0;

    if (tx_valid_i) begin
      hist_d = {hist[MAX_LAT-2:0], tx_bit_i};
      if (fill != FW'(MAX_LAT)) fill_d = fill + FW'(1);
    end

    case (state)
      ST_SEARCH: begin
        if (compare) begin
          if (hit) begin
            if (run == RW'(LOCK_WIN - 1)) begin
              state_d   = ST_LOCKED;
              locked_d  = 1'b1;
              latency_d = cand;
              run_d     = '0;
              win_ct_d  = '0;
              win_err_d = '0;
            end else begin
              run_d = run + RW'(1);
            end
          end else begin
            run_d  = '0;
            cand_d = cand + LW'(1);
          end
        end
      end
      ST_LOCKED: begin
        if (compare && !clear_i) begin
          if (bit_ct_o != '1) bit_ct_d = bit_ct_o + CNT_W'(1);
          if (!hit) begin
            if (err_ct_o != '1) err_ct_d = err_ct_o + CNT_W'(1);
            err_flag_d = 1'b1;
          end
          // Loss check takes priority over the window rollover.
          if (!hit && win_err == EW'(LOSS_THR - 1)) begin
            state_d   = ST_SEARCH;
            locked_d  = 1'b0;
            run_d     = '0;
            win_ct_d  = '0;
            win_err_d = '0;
          end else if (win_ct == RW'(LOCK_WIN - 1)) begin
            win_ct_d  = '0;
            win_err_d = '0;
          end else begin
            win_ct_d  = win_ct + RW'(1);
            win_err_d = win_err + EW'(!hit);
          end
        end
      end
      default: state_d = ST_SEARCH;
    endcase

    if (clear_i) begin
      bit_ct_d  = '0;
      err_ct_d  = '0;
      win_ct_d  = '0;
      win_err_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_SEARCH;
      hist       <= '0;
      fill       <= '0;
      cand       <= '0;
      run        <= '0;
      win_ct     <= '0;
      win_err    <= '0;
      locked_o   <= 1'b0;
      latency_o  <= '0;
      bit_ct_o   <= '0;
      err_ct_o   <= '0;
      err_flag_o <= 1'b0;
    end else begin
      state      <= state_d;
      hist       <= hist_d;
      fill       <= fill_d;
      cand       <= cand_d;
      run        <= run_d;
      win_ct     <= win_ct_d;
      win_err    <= win_err_d;
      locked_o   <= locked_d;
      latency_o  <= latency_d;
      bit_ct_o   <= bit_ct_d;
      err_ct_o   <= err_ct_d;
      err_flag_o <= err_flag_d;
    end
  end

endmodule
